// File: rtl/fizzbuzz_formatter.sv
// FizzBuzz line formatter: sequences an external 3-digit BCD counter and streams
// one ASCII line per count ("Fizz"/"Buzz"/"FizzBuzz"/number, then CR LF) over valid/ready.
module fizzbuzz_formatter #(
  parameter int unsigned MAX_COUNT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic       counter_clear,
  output logic       increment,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] MaxD2 = 4'((MAX_COUNT / 100) % 10);
  localparam logic [3:0] MaxD1 = 4'((MAX_COUNT / 10) % 10);
  localparam logic [3:0] MaxD0 = 4'(MAX_COUNT % 10);

  typedef enum logic [2:0] {StIdle, StClear, StInc, StSettle, StEmit} state_e;
  typedef enum logic [1:0] {LineNum, LineFizz, LineBuzz, LineFizzBuzz} line_e;

  state_e     state_q, state_d;
  line_e      line_q, line_d;
  logic [1:0] mod3_q, mod3_d;
  logic [2:0] mod5_q, mod5_d;
  logic [3:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;

  logic [7:0] tx_byte;
  logic [3:0] digit_sel;
  logic       last_byte;
  logic       at_max;

  function automatic logic [7:0] fizz_char(input logic [1:0] i);
    case (i)
      2'd0:    fizz_char = 8'h46; // F
      2'd1:    fizz_char = 8'h69; // i
      default: fizz_char = 8'h7A; // z
    endcase
  endfunction

  function automatic logic [7:0] buzz_char(input logic [1:0] i);
    case (i)
      2'd0:    buzz_char = 8'h42; // B
      2'd1:    buzz_char = 8'h75; // u
      default: buzz_char = 8'h7A; // z
    endcase
  endfunction

  assign last_byte = (idx_q == len_q + 4'd1);
  assign at_max    = ({d2_q, d1_q, d0_q} == {MaxD2, MaxD1, MaxD0});

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    mod3_d        = mod3_q;
    mod5_d        = mod5_q;
    d2_d          = d2_q;
    d1_d          = d1_q;
    d0_d          = d0_q;
    len_d         = len_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    counter_clear = 1'b0;
    increment     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        counter_clear = 1'b1;
        mod3_d        = 2'd0;
        mod5_d        = 3'd0;
        state_d       = StInc;
      end
      StInc: begin
        increment = 1'b1;
        mod3_d    = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
        mod5_d    = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
        state_d   = StSettle;
      end
      StSettle: begin
        d2_d  = digit2;
        d1_d  = digit1;
        d0_d  = digit0;
        idx_d = 4'd0;
        if (mod3_q == 2'd0 && mod5_q == 3'd0) begin
          line_d = LineFizzBuzz;
          len_d  = 4'd8;
        end else if (mod3_q == 2'd0) begin
          line_d = LineFizz;
          len_d  = 4'd4;
        end else if (mod5_q == 3'd0) begin
          line_d = LineBuzz;
          len_d  = 4'd4;
        end else begin
          line_d = LineNum;
          len_d  = (digit2 != 4'd0) ? 4'd3 : (digit1 != 4'd0) ? 4'd2 : 4'd1;
        end
        state_d = StEmit;
      end
      StEmit: begin
        if (tx_ready) begin
          if (last_byte) begin
            idx_d = 4'd0;
            if (at_max) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StInc;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Numbers are right-aligned in the 3 latched digits; skip suppressed leading zeros.
  always_comb begin
    tx_byte   = 8'h00;
    digit_sel = idx_q + (4'd3 - len_q);
    if (idx_q == len_q) begin
      tx_byte = 8'h0D;
    end else if (last_byte) begin
      tx_byte = 8'h0A;
    end else begin
      unique case (line_q)
        LineFizz:     tx_byte = fizz_char(idx_q[1:0]);
        LineBuzz:     tx_byte = buzz_char(idx_q[1:0]);
        LineFizzBuzz: tx_byte = idx_q[2] ? buzz_char(idx_q[1:0]) : fizz_char(idx_q[1:0]);
        default: begin
          case (digit_sel)
            4'd0:    tx_byte = {4'h3, d2_q};
            4'd1:    tx_byte = {4'h3, d1_q};
            default: tx_byte = {4'h3, d0_q};
          endcase
        end
      endcase
    end
  end

  assign tx_valid = (state_q == StEmit);
  assign tx_data  = tx_valid ? tx_byte : 8'h00;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      line_q  <= LineNum;
      mod3_q  <= 2'd0;
      mod5_q  <= 3'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      mod3_q  <= mod3_d;
      mod5_q  <= mod5_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule
